// File: rtl/stack_controller_if.sv
// ---------------------------------------------------------------------------
// stack_controller_if
//   Bundles every non-clock, non-reset signal of the stack controller.
//   Request side : REQ_VALID, REQ_OP, PUSH_DATA  -> controller, REQ_READY back.
//   Response side: RESP_VALID, RESP_DATA, RESP_ERR -> consumer, RESP_READY back.
//   Status       : TOS_OUT (entry count), OVERFLOW, UNDERFLOW (sticky).
//   RAM bus      : MEM_ADDR, MEM_WDATA, MEM_WE, MEM_RE -> RAM, MEM_RDATA back
//                  (synchronous RAM, read data one cycle after MEM_RE).
//   Modports:
//     slave  - the controller itself.
//     master - its environment (requester, response consumer and the RAM).
// ---------------------------------------------------------------------------
interface stack_controller_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 12
);
    logic                  REQ_VALID;
    logic [1:0]            REQ_OP;
    logic [DATA_WIDTH-1:0] PUSH_DATA;
    logic                  REQ_READY;
    logic                  RESP_VALID;
    logic                  RESP_READY;
    logic [DATA_WIDTH-1:0] RESP_DATA;
    logic                  RESP_ERR;
    logic [ADDR_WIDTH:0]   TOS_OUT;
    logic                  OVERFLOW;
    logic                  UNDERFLOW;
    logic [ADDR_WIDTH-1:0] MEM_ADDR;
    logic [DATA_WIDTH-1:0] MEM_WDATA;
    logic                  MEM_WE;
    logic                  MEM_RE;
    logic [DATA_WIDTH-1:0] MEM_RDATA;

    modport slave (
        input  REQ_VALID, REQ_OP, PUSH_DATA, RESP_READY, MEM_RDATA,
        output REQ_READY, RESP_VALID, RESP_DATA, RESP_ERR, TOS_OUT,
               OVERFLOW, UNDERFLOW, MEM_ADDR, MEM_WDATA, MEM_WE, MEM_RE
    );

    modport master (
        output REQ_VALID, REQ_OP, PUSH_DATA, RESP_READY, MEM_RDATA,
        input  REQ_READY, RESP_VALID, RESP_DATA, RESP_ERR, TOS_OUT,
               OVERFLOW, UNDERFLOW, MEM_ADDR, MEM_WDATA, MEM_WE, MEM_RE
    );
endinterface

// File: rtl/stack_controller.sv
// ---------------------------------------------------------------------------
// stack_controller
//   LIFO controller in front of an external synchronous stack RAM.
//   Opcodes: 00 CLEAR, 01 PUSH, 10 POP, 11 PEEK.
//   Ports:
//     clk   - single clock, rising edge.
//     rst_n - asynchronous active-low reset.
//     bus   - stack_controller_if.slave (request/response handshakes,
//             status outputs and the RAM bus).
//   Flow: IDLE accepts a request; PUSH -> WRITE -> IDLE;
//         POP/PEEK -> READ -> WAIT -> RESP -> IDLE;
//         underflowing POP/PEEK -> RESP directly; CLEAR and overflowing
//         PUSH complete in IDLE.
// ---------------------------------------------------------------------------
module stack_controller #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    stack_controller_if.slave bus
);
    localparam logic [ADDR_WIDTH:0]   DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0]   ONE   = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH-1:0] ONE_A = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [1:0] OP_CLEAR = 2'b00;
    localparam logic [1:0] OP_PUSH  = 2'b01;
    localparam logic [1:0] OP_POP   = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_READ,
        S_WAIT,
        S_RESP
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH:0]   tos_q, tos_d;
    logic [1:0]            op_q, op_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [DATA_WIDTH-1:0] resp_data_q, resp_data_d;
    logic                  resp_err_q, resp_err_d;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;

    logic                  req_ready;
    logic                  resp_valid;
    logic                  mem_we;
    logic                  mem_re;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;

    // Address of the top entry. When the stack is full the low bits of TOS
    // are zero and the subtraction wraps to DEPTH-1, which is exactly right.
    logic [ADDR_WIDTH-1:0] top_addr;
    assign top_addr = tos_q[ADDR_WIDTH-1:0] - ONE_A;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            tos_q       <= '0;
            op_q        <= OP_CLEAR;
            data_q      <= '0;
            resp_data_q <= '0;
            resp_err_q  <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            tos_q       <= tos_d;
            op_q        <= op_d;
            data_q      <= data_d;
            resp_data_q <= resp_data_d;
            resp_err_q  <= resp_err_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        tos_d       = tos_q;
        op_d        = op_q;
        data_d      = data_q;
        resp_data_d = resp_data_q;
        resp_err_d  = resp_err_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        req_ready   = 1'b0;
        resp_valid  = 1'b0;
        mem_we      = 1'b0;
        mem_re      = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;

        unique case (state_q)
            S_IDLE: begin
                req_ready = 1'b1;
                if (bus.REQ_VALID) begin
                    op_d   = bus.REQ_OP;
                    data_d = bus.PUSH_DATA;
                    unique case (bus.REQ_OP)
                        OP_CLEAR: begin
                            tos_d       = '0;
                            overflow_d  = 1'b0;
                            underflow_d = 1'b0;
                        end
                        OP_PUSH: begin
                            if (tos_q == DEPTH) begin
                                overflow_d = 1'b1;
                            end else begin
                                state_d = S_WRITE;
                            end
                        end
                        default: begin
                            // POP and PEEK share the read path.
                            if (tos_q == '0) begin
                                underflow_d = 1'b1;
                                resp_data_d = '0;
                                resp_err_d  = 1'b1;
                                state_d     = S_RESP;
                            end else begin
                                state_d = S_READ;
                            end
                        end
                    endcase
                end
            end
            S_WRITE: begin
                mem_we    = 1'b1;
                mem_addr  = tos_q[ADDR_WIDTH-1:0];
                mem_wdata = data_q;
                tos_d     = tos_q + ONE;
                state_d   = S_IDLE;
            end
            S_READ: begin
                mem_re   = 1'b1;
                mem_addr = top_addr;
                if (op_q == OP_POP) begin
                    tos_d = tos_q - ONE;
                end
                state_d = S_WAIT;
            end
            S_WAIT: begin
                resp_data_d = bus.MEM_RDATA;
                resp_err_d  = 1'b0;
                state_d     = S_RESP;
            end
            S_RESP: begin
                resp_valid = 1'b1;
                if (bus.RESP_READY) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.REQ_READY  = req_ready;
    assign bus.RESP_VALID = resp_valid;
    assign bus.RESP_DATA  = resp_data_q;
    assign bus.RESP_ERR   = resp_err_q;
    assign bus.TOS_OUT    = tos_q;
    assign bus.OVERFLOW   = overflow_q;
    assign bus.UNDERFLOW  = underflow_q;
    assign bus.MEM_ADDR   = mem_addr;
    assign bus.MEM_WDATA  = mem_wdata;
    assign bus.MEM_WE     = mem_we;
    assign bus.MEM_RE     = mem_re;

endmodule

// File: tb/tb_stack_controller.sv
// ---------------------------------------------------------------------------
// tb_stack_controller
//   Directed bench for stack_controller (DATA_WIDTH=8, ADDR_WIDTH=2, so the
//   stack holds four entries). A queue-based LIFO model tracks what the
//   controller must report; a negedge process compares outputs with it, and
//   the directed sequence pins literal values on top of that.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_stack_controller;
    localparam int DW = 8;
    localparam int AW = 2;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    stack_controller_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    stack_controller #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Stack RAM: synchronous write, registered read.
    logic [DW-1:0] ram [DEPTH];
    always @(posedge clk) begin
        if (bus.MEM_WE) ram[bus.MEM_ADDR] <= bus.MEM_WDATA;
        if (bus.MEM_RE) bus.MEM_RDATA <= ram[bus.MEM_ADDR];
    end

    // ---------------- transaction-level model ----------------
    logic [DW-1:0] model_q[$];
    bit            m_ovf, m_unf;
    bit            wr_pend, rd_pend, resp_pend;
    int            exp_wr_addr, exp_rd_addr;
    logic [DW-1:0] exp_wr_data, exp_rsp_data;
    bit            exp_rsp_err;

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                model_q.delete();
                m_ovf = 0; m_unf = 0;
                wr_pend = 0; rd_pend = 0; resp_pend = 0;
            end else if (bus.REQ_VALID && bus.REQ_READY) begin
                case (bus.REQ_OP)
                    2'b00: begin
                        model_q.delete();
                        m_ovf = 0; m_unf = 0;
                    end
                    2'b01: begin
                        if (model_q.size() == DEPTH) begin
                            m_ovf = 1;
                        end else begin
                            exp_wr_addr = model_q.size();
                            exp_wr_data = bus.PUSH_DATA;
                            wr_pend = 1;
                            model_q.push_back(bus.PUSH_DATA);
                        end
                    end
                    default: begin
                        resp_pend = 1;
                        if (model_q.size() == 0) begin
                            m_unf = 1;
                            exp_rsp_data = '0;
                            exp_rsp_err = 1;
                        end else begin
                            exp_rsp_data = model_q[model_q.size()-1];
                            exp_rsp_err = 0;
                            exp_rd_addr = model_q.size() - 1;
                            rd_pend = 1;
                            if (bus.REQ_OP == 2'b10) void'(model_q.pop_back());
                        end
                    end
                endcase
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    int we_count = 0;
    int re_count = 0;
    initial begin
        forever begin
            @(negedge clk);
            if (bus.MEM_WE && bus.MEM_RE) check("we_and_re", 1, 0);
            if (bus.MEM_WE) begin
                we_count++;
                check("we_expected", 32'(wr_pend), 1);
                check("we_addr", 32'(bus.MEM_ADDR), 32'(exp_wr_addr));
                check("we_data", 32'(bus.MEM_WDATA), 32'(exp_wr_data));
                wr_pend = 0;
            end
            if (bus.MEM_RE) begin
                re_count++;
                check("re_expected", 32'(rd_pend), 1);
                check("re_addr", 32'(bus.MEM_ADDR), 32'(exp_rd_addr));
                rd_pend = 0;
            end
            if (bus.REQ_READY || bus.RESP_VALID) begin
                check("tos", 32'(bus.TOS_OUT), 32'(model_q.size()));
                check("ovf", 32'(bus.OVERFLOW), 32'(m_ovf));
                check("unf", 32'(bus.UNDERFLOW), 32'(m_unf));
            end
            if (bus.REQ_READY) begin
                check("idle_resp_valid", 32'(bus.RESP_VALID), 0);
                check("idle_mem_we", 32'(bus.MEM_WE), 0);
                check("idle_mem_re", 32'(bus.MEM_RE), 0);
            end
            if (bus.RESP_VALID) begin
                check("resp_expected", 32'(resp_pend), 1);
                check("resp_data", 32'(bus.RESP_DATA), 32'(exp_rsp_data));
                check("resp_err", 32'(bus.RESP_ERR), 32'(exp_rsp_err));
                if (bus.RESP_READY) resp_pend = 0;
            end
        end
    end

    // ---------------- directed stimulus ----------------
    // Called at posedge+2. Returns response data/err, cycles from the first
    // post-accept cycle to RESP_VALID, and MEM_WE in the first post-accept cycle.
    task automatic do_op(input logic [1:0] op, input logic [DW-1:0] d, input int stall,
                         output logic [DW-1:0] rd, output logic re, output int lat,
                         output logic we_now);
        int n;
        rd = '0; re = 1'b0; lat = -1;
        n = 0;
        while (!bus.REQ_READY && n < 50) begin @(posedge clk); #2; n++; end
        if (n >= 50) check("timeout_ready", 0, 1);
        bus.REQ_VALID = 1'b1; bus.REQ_OP = op; bus.PUSH_DATA = d;
        bus.RESP_READY = (stall == 0);
        @(posedge clk); #2;
        bus.REQ_VALID = 1'b0;
        we_now = bus.MEM_WE;
        if (op[1]) begin
            n = 0;
            while (!bus.RESP_VALID && n < 20) begin @(posedge clk); #2; n++; end
            if (n >= 20) check("timeout_resp", 0, 1);
            lat = n;
            rd = bus.RESP_DATA; re = bus.RESP_ERR;
            for (int i = 0; i < stall; i++) begin
                check("stall_valid", 32'(bus.RESP_VALID), 1);
                check("stall_data", 32'(bus.RESP_DATA), 32'(rd));
                check("stall_err", 32'(bus.RESP_ERR), 32'(re));
                check("stall_ready", 32'(bus.REQ_READY), 0);
                @(posedge clk); #2;
            end
            if (stall > 0) begin
                bus.RESP_READY = 1'b1;
                @(posedge clk); #2;
                check("stall_release_idle", 32'(bus.REQ_READY), 1);
            end else begin
                @(posedge clk); #2;
            end
        end else if (op == 2'b01) begin
            @(posedge clk); #2;
        end
        $display("op=%0d data=0x%02h -> rdata=0x%02h err=%0d lat=%0d tos=%0d ovf=%0d unf=%0d",
                 op, d, rd, re, lat, bus.TOS_OUT, bus.OVERFLOW, bus.UNDERFLOW);
    endtask

    logic [DW-1:0] rd;
    logic          re, we_now;
    int            lat, snap;

    initial begin
        bus.REQ_VALID = 1'b0; bus.REQ_OP = 2'b00; bus.PUSH_DATA = '0; bus.RESP_READY = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        check("rst_tos", 32'(bus.TOS_OUT), 0);
        check("rst_resp_valid", 32'(bus.RESP_VALID), 0);
        check("rst_mem_we", 32'(bus.MEM_WE), 0);
        check("rst_mem_addr", 32'(bus.MEM_ADDR), 0);
        rst_n = 1'b1;
        @(posedge clk); #2;
        check("rst_req_ready", 32'(bus.REQ_READY), 1);

        // PUSH A5, PUSH 3C, POP -> 3C, TOS 1
        do_op(2'b01, 8'hA5, 0, rd, re, lat, we_now);
        check("push_latency_we", 32'(we_now), 1);
        do_op(2'b01, 8'h3C, 0, rd, re, lat, we_now);
        do_op(2'b10, 8'h00, 0, rd, re, lat, we_now);
        check("r030_data", 32'(rd), 32'h3C);
        check("r030_err", 32'(re), 0);
        check("r030_lat", 32'(lat), 2);
        check("r030_tos", 32'(bus.TOS_OUT), 1);
        check("r030_writes", 32'(we_count), 2);
        do_op(2'b10, 8'h00, 0, rd, re, lat, we_now);
        check("pop_a5", 32'(rd), 32'hA5);

        // PUSH 11, PEEK, POP
        do_op(2'b01, 8'h11, 0, rd, re, lat, we_now);
        do_op(2'b11, 8'h00, 0, rd, re, lat, we_now);
        check("r031_peek", 32'(rd), 32'h11);
        check("r031_peek_tos", 32'(bus.TOS_OUT), 1);
        do_op(2'b10, 8'h00, 0, rd, re, lat, we_now);
        check("r031_pop", 32'(rd), 32'h11);
        check("r031_pop_tos", 32'(bus.TOS_OUT), 0);

        // POP on empty
        snap = re_count;
        do_op(2'b10, 8'h00, 0, rd, re, lat, we_now);
        check("r032_data", 32'(rd), 0);
        check("r032_err", 32'(re), 1);
        check("r032_lat", 32'(lat), 0);
        check("r032_unf", 32'(bus.UNDERFLOW), 1);
        check("r032_no_re", 32'(re_count), 32'(snap));
        do_op(2'b00, 8'h00, 0, rd, re, lat, we_now);
        check("clear_unf", 32'(bus.UNDERFLOW), 0);

        // Fill to overflow
        snap = we_count;
        for (int i = 0; i < 5; i++) do_op(2'b01, 8'(8'h10 + i), 0, rd, re, lat, we_now);
        check("r033_writes", 32'(we_count - snap), 4);
        check("r033_ovf", 32'(bus.OVERFLOW), 1);
        check("r033_tos", 32'(bus.TOS_OUT), 4);

        // Stalled POP from full stack
        do_op(2'b10, 8'h00, 5, rd, re, lat, we_now);
        check("r034_data", 32'(rd), 32'h13);
        check("r034_tos", 32'(bus.TOS_OUT), 3);
        check("r034_ovf_sticky", 32'(bus.OVERFLOW), 1);
        do_op(2'b00, 8'h00, 0, rd, re, lat, we_now);
        check("r033_clear_tos", 32'(bus.TOS_OUT), 0);
        check("r033_clear_ovf", 32'(bus.OVERFLOW), 0);

        // Reset during WRITE
        do_op(2'b01, 8'h55, 0, rd, re, lat, we_now);
        bus.REQ_VALID = 1'b1; bus.REQ_OP = 2'b01; bus.PUSH_DATA = 8'h66;
        @(posedge clk); #2;
        bus.REQ_VALID = 1'b0;
        check("r035_in_write", 32'(bus.MEM_WE), 1);
        snap = we_count;
        rst_n = 1'b0;
        #1;
        check("r035_we_dropped", 32'(bus.MEM_WE), 0);
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        check("r035_no_we", 32'(we_count), 32'(snap));
        check("r035_tos", 32'(bus.TOS_OUT), 0);
        check("r035_ready", 32'(bus.REQ_READY), 1);
        $display("reset during write: tos=%0d ready=%0d", bus.TOS_OUT, bus.REQ_READY);

        // Operational after reset
        do_op(2'b01, 8'h77, 0, rd, re, lat, we_now);
        do_op(2'b10, 8'h00, 0, rd, re, lat, we_now);
        check("post_rst_pop", 32'(rd), 32'h77);

        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/stack_controller.md
STACK_CONTROLLER -- requirements
Module: stack_controller

Interface
REQ-001 SHALL have parameters: DATA_WIDTH, default 8, stack word width; ADDR_WIDTH, default 12, stack RAM address width; DEPTH equals 2^ADDR_WIDTH entries.
REQ-002 SHALL have clk  input  1  single clock; all state updates on the rising edge.
REQ-003 SHALL have reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have REQ_VALID  input  1  request present.
REQ-005 SHALL have REQ_OP  input  2  request opcode: 00 CLEAR, 01 PUSH, 10 POP, 11 PEEK.
REQ-006 SHALL have PUSH_DATA  input  DATA_WIDTH  word to push.
REQ-007 SHALL have REQ_READY  output  1  controller can accept a request.
REQ-008 SHALL have RESP_VALID  output  1  pop/peek result available.
REQ-009 SHALL have RESP_READY  input  1  consumer accepts result.
REQ-010 SHALL have RESP_DATA  output  DATA_WIDTH  popped/peeked word.
REQ-011 SHALL have RESP_ERR  output  1  response carries an underflow error.
REQ-012 SHALL have TOS_OUT  output  ADDR_WIDTH+1  current entry count.
REQ-013 SHALL have OVERFLOW, UNDERFLOW  output  1 each  sticky error flags.
REQ-014 SHALL have MEM_ADDR  output  ADDR_WIDTH, MEM_WDATA  output  DATA_WIDTH, MEM_WE  output  1, MEM_RE  output  1, MEM_RDATA  input  DATA_WIDTH; the stack RAM is synchronous, with read data valid one cycle after MEM_RE.

Function
REQ-015 SHALL implement FSM states IDLE, WRITE, READ, WAIT, RESP.
REQ-016 SHALL assert REQ_READY only in IDLE; a request is accepted when REQ_VALID and REQ_READY are both high at an edge, and REQ_OP/PUSH_DATA SHALL be registered at acceptance.
REQ-017 CLEAR SHALL set TOS to 0, clear OVERFLOW/UNDERFLOW at the acceptance edge, and remain in IDLE with no memory access.
REQ-018 PUSH with TOS < DEPTH SHALL go to WRITE; in WRITE it SHALL drive MEM_WE=1, MEM_ADDR=TOS[ADDR_WIDTH-1:0], MEM_WDATA=registered data; TOS SHALL increment at the end of WRITE, and the FSM SHALL return to IDLE.
REQ-019 PUSH with TOS == DEPTH SHALL set OVERFLOW, perform no write, leave TOS unchanged, and remain in IDLE.
REQ-020 POP/PEEK with TOS > 0 SHALL go to READ; in READ it SHALL drive MEM_RE=1 with MEM_ADDR=TOS-1; POP SHALL decrement TOS at the end of READ, while PEEK SHALL not change TOS.
REQ-021 WAIT SHALL capture MEM_RDATA into RESP_DATA, set RESP_ERR=0, and go to RESP.
REQ-022 POP/PEEK with TOS == 0 SHALL set UNDERFLOW, set RESP_DATA=0 and RESP_ERR=1, go directly to RESP, and perform no memory access.
REQ-023 RESP SHALL hold RESP_VALID=1 with RESP_DATA/RESP_ERR stable until RESP_READY is high at an edge, then return to IDLE.
REQ-024 Latency: PUSH accepted at edge N writes in cycle N+1, and REQ_READY reasserts in cycle N+2; valid POP/PEEK accepted at N has MEM_RE in N+1, capture in N+2, and RESP_VALID from N+3.
REQ-025 MEM_WE and MEM_RE SHALL never both be high, and SHALL be 0 outside WRITE and READ respectively.
REQ-026 OVERFLOW/UNDERFLOW SHALL stay set until CLEAR or reset.
REQ-027 TOS arithmetic SHALL use ADDR_WIDTH+1 bits and SHALL never wrap.

Reset
REQ-028 While reset is low (asynchronously): state=IDLE, TOS_OUT=0, RESP_VALID=0, RESP_DATA=0, RESP_ERR=0, OVERFLOW=0, UNDERFLOW=0, MEM_WE=0, MEM_RE=0, MEM_ADDR=0, MEM_WDATA=0; REQ_READY SHALL be 1 once reset is released.
REQ-029 Reset asserted mid-operation (WRITE, READ, WAIT or RESP) SHALL abort that operation, suppress any pending write, and drop any pending response.

Verification
REQ-030 PUSH 0xA5, PUSH 0x3C, then POP -> writes to addr 0 and addr 1; the POP responds with 0x3C, RESP_ERR=0, and TOS_OUT=1.
REQ-031 PEEK after PUSH 0x11 -> RESP_DATA=0x11 with TOS_OUT still 1; a following POP returns 0x11 and TOS_OUT=0.
REQ-032 POP on an empty stack -> RESP_VALID with RESP_DATA=0, RESP_ERR=1, UNDERFLOW=1, and MEM_RE never asserted.
REQ-033 With ADDR_WIDTH=2: five PUSHes -> four writes to addr 0..3; the fifth sets OVERFLOW with TOS_OUT=4; a subsequent CLEAR gives TOS_OUT=0 and OVERFLOW=0.
REQ-034 POP with RESP_READY held low for 5 cycles -> RESP_VALID and RESP_DATA stable throughout, REQ_READY=0, and IDLE entered the cycle after RESP_READY rises.
REQ-035 Reset pulsed low during WRITE -> no MEM_WE after reset, TOS_OUT=0, and REQ_READY=1 after reset release.
